// File: rtl/rtb_pkg.sv
// Shared definitions for the retirement trace buffer.
// RTB_CYCLE_STAMP_EN: when defined, each record carries a cycle stamp above its inum.
package rtb_pkg;

   // Record kind encoding as it appears in the trace stream
   localparam logic [2:0] KIND_NOP  = 3'd0;
   localparam logic [2:0] KIND_REG  = 3'd1;
   localparam logic [2:0] KIND_LD   = 3'd2;
   localparam logic [2:0] KIND_STU  = 3'd3;
   localparam logic [2:0] KIND_ST   = 3'd4;
   localparam logic [2:0] KIND_HALT = 3'd5;

   // Everything below the inum: kind, pc, wrReg, wrData, memAddr, memData
   localparam int PAYLOAD_W = 70;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] pc;
      logic [2:0]  wrReg;
      logic [15:0] wrData;
      logic [15:0] memAddr;
      logic [15:0] memData;
   } payload_t;

   // Full record width for a given counter width
   function automatic int recWidth(input int cntW);
`ifdef RTB_CYCLE_STAMP_EN
      return 2 * cntW + PAYLOAD_W;
`else
      return cntW + PAYLOAD_W;
`endif
   endfunction

   // Classify one retirement and zero the fields its kind does not use
   function automatic payload_t classify(input logic halt, input logic regWrite,
                                         input logic memRead, input logic memWrite,
                                         input logic [15:0] pc, input logic [2:0] wrReg,
                                         input logic [15:0] wrData, input logic [15:0] memAddr,
                                         input logic [15:0] memData);
      payload_t p;
      p    = '0;
      p.pc = pc;
      if (halt)                       p.kind = KIND_HALT;
      else if (regWrite && memWrite)  p.kind = KIND_STU;
      else if (regWrite && memRead)   p.kind = KIND_LD;
      else if (regWrite)              p.kind = KIND_REG;
      else if (memWrite)              p.kind = KIND_ST;
      else                            p.kind = KIND_NOP;
      if (p.kind == KIND_REG || p.kind == KIND_LD || p.kind == KIND_STU) begin
         p.wrReg  = wrReg;
         p.wrData = wrData;
      end
      if (p.kind == KIND_LD || p.kind == KIND_ST || p.kind == KIND_STU)
         p.memAddr = memAddr;
      if (p.kind == KIND_ST || p.kind == KIND_STU)
         p.memData = memData;
      return p;
   endfunction

endpackage

// File: rtl/rtb_fifo.sv
// Record FIFO: up to NUM_WR in-order writes and one read per cycle.
// freeSlots already credits the slot released by this cycle's read.
module rtb_fifo #(
   parameter int W      = 8,
   parameter int DEPTH  = 8,
   parameter int NUM_WR = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = $clog2(DEPTH + 1),
   localparam int WC_W  = $clog2(NUM_WR + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WC_W-1:0]  wrCount,
   input  logic [W-1:0]     wrData [NUM_WR],
   input  logic             rdEn,
   output logic [W-1:0]     rdData,
   output logic             notEmpty,
   output logic [OCC_W-1:0] freeSlots
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [OCC_W-1:0] occupancy;
   logic             deq;

   assign notEmpty  = (occupancy != '0);
   assign deq       = rdEn & notEmpty;
   assign freeSlots = OCC_W'(DEPTH) - occupancy + OCC_W'(deq);
   assign rdData    = mem[rdPtr];

   // Store the compacted records at consecutive slots from the write pointer
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_WR; k++) begin
         if (k < int'(wrCount))
            mem[wrPtr + PTR_W'(k)] <= wrData[k];
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
      end else begin
         wrPtr     <= wrPtr + PTR_W'(wrCount);
         rdPtr     <= rdPtr + PTR_W'(deq);
         occupancy <= occupancy + OCC_W'(wrCount) - OCC_W'(deq);
      end
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement monitor: classifies, numbers and buffers retiring instructions.
// RTB_CYCLE_STAMP_EN: when defined, records carry the sampling cycle_count above inum.
module retire_trace_buffer
   import rtb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 32,
   localparam int REC_W = recWidth(CNT_W)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    ret_valid,
   input  logic [16*NUM_CH-1:0] ret_pc,
   input  logic [NUM_CH-1:0]    ret_reg_write,
   input  logic [3*NUM_CH-1:0]  ret_wr_reg,
   input  logic [16*NUM_CH-1:0] ret_wr_data,
   input  logic [NUM_CH-1:0]    ret_mem_read,
   input  logic [NUM_CH-1:0]    ret_mem_write,
   input  logic [16*NUM_CH-1:0] ret_mem_addr,
   input  logic [16*NUM_CH-1:0] ret_mem_data,
   input  logic [NUM_CH-1:0]    ret_halt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REC_W-1:0]     out_rec,
   output logic [CNT_W-1:0]     inst_count,
   output logic [CNT_W-1:0]     cycle_count,
   output logic                 halted,
   output logic                 done,
   output logic                 overflow,
   output logic [CNT_W-1:0]     drop_count
);

   localparam int FREE_W = $clog2(DEPTH + 1);
   localparam int RANK_W = $clog2(NUM_CH + 1);

   logic [FREE_W-1:0] freeSlots;
   logic [RANK_W-1:0] acceptCount;
   logic [RANK_W-1:0] writeCount;
   logic              haltNow;
   logic [REC_W-1:0]  wrRecs [NUM_CH];
   logic [REC_W-1:0]  headRec;

   // Walk the channels oldest first: number, classify and compact the records that fit
   always_comb begin
      logic              blocked;
      logic [RANK_W-1:0] rank;
      payload_t          p;
      logic [CNT_W-1:0]  inum;
      blocked = halted;
      rank    = '0;
      p       = '0;
      inum    = '0;
      haltNow = 1'b0;
      for (int c = 0; c < NUM_CH; c++) wrRecs[c] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!blocked && ret_valid[c]) begin
            p    = classify(ret_halt[c], ret_reg_write[c], ret_mem_read[c], ret_mem_write[c],
                            ret_pc[16*c +: 16], ret_wr_reg[3*c +: 3], ret_wr_data[16*c +: 16],
                            ret_mem_addr[16*c +: 16], ret_mem_data[16*c +: 16]);
            inum = inst_count + CNT_W'(rank);
            if (int'(rank) < int'(freeSlots)) begin
`ifdef RTB_CYCLE_STAMP_EN
               wrRecs[rank] = {cycle_count, inum, p};
`else
               wrRecs[rank] = {inum, p};
`endif
            end
            rank = rank + 1'b1;
            if (ret_halt[c]) begin
               blocked = 1'b1;
               haltNow = 1'b1;
            end
         end
      end
      acceptCount = rank;
      writeCount  = (int'(rank) < int'(freeSlots)) ? rank : RANK_W'(freeSlots);
   end

   rtb_fifo #(
      .W      (REC_W),
      .DEPTH  (DEPTH),
      .NUM_WR (NUM_CH)
   ) fifo (
      .clk       (clk),
      .rst       (rst),
      .wrCount   (writeCount),
      .wrData    (wrRecs),
      .rdEn      (out_ready),
      .rdData    (headRec),
      .notEmpty  (out_valid),
      .freeSlots (freeSlots)
   );

   assign out_rec = out_valid ? headRec : '0;
   assign done    = halted & ~out_valid;

   // Counters, sticky halt and overflow status; dropped records still consume an inum
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_count  <= '0;
         cycle_count <= '0;
         halted      <= 1'b0;
         overflow    <= 1'b0;
         drop_count  <= '0;
      end else begin
         inst_count <= inst_count + CNT_W'(acceptCount);
         if (!halted)
            cycle_count <= cycle_count + CNT_W'(1);
         if (haltNow)
            halted <= 1'b1;
         if (acceptCount != writeCount) begin
            overflow   <= 1'b1;
            drop_count <= drop_count + CNT_W'(acceptCount - writeCount);
         end
      end
   end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed scoreboard bench for retire_trace_buffer (NUM_CH=2, DEPTH=8, CNT_W=32).
module tb_retire_trace_buffer;
   import rtb_pkg::*;

   localparam int NUM_CH = 2;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 32;
   localparam int REC_W  = recWidth(CNT_W);
   localparam int BASE_W = CNT_W + PAYLOAD_W;

   logic                 clk;
   logic                 rst;
   logic [NUM_CH-1:0]    ret_valid;
   logic [16*NUM_CH-1:0] ret_pc;
   logic [NUM_CH-1:0]    ret_reg_write;
   logic [3*NUM_CH-1:0]  ret_wr_reg;
   logic [16*NUM_CH-1:0] ret_wr_data;
   logic [NUM_CH-1:0]    ret_mem_read;
   logic [NUM_CH-1:0]    ret_mem_write;
   logic [16*NUM_CH-1:0] ret_mem_addr;
   logic [16*NUM_CH-1:0] ret_mem_data;
   logic [NUM_CH-1:0]    ret_halt;
   logic                 out_valid;
   logic                 out_ready;
   logic [REC_W-1:0]     out_rec;
   logic [CNT_W-1:0]     inst_count;
   logic [CNT_W-1:0]     cycle_count;
   logic                 halted;
   logic                 done;
   logic                 overflow;
   logic [CNT_W-1:0]     drop_count;

   logic [BASE_W-1:0] sb [$];
   logic [CNT_W-1:0]  expInst;
   logic [CNT_W-1:0]  expCycle;
   logic [CNT_W-1:0]  expDrop;
   logic              expHalted;
   logic              expOverflow;
   int                nCompared;
   int                nMismatched;

   retire_trace_buffer #(
      .NUM_CH (NUM_CH),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ret_valid     (ret_valid),
      .ret_pc        (ret_pc),
      .ret_reg_write (ret_reg_write),
      .ret_wr_reg    (ret_wr_reg),
      .ret_wr_data   (ret_wr_data),
      .ret_mem_read  (ret_mem_read),
      .ret_mem_write (ret_mem_write),
      .ret_mem_addr  (ret_mem_addr),
      .ret_mem_data  (ret_mem_data),
      .ret_halt      (ret_halt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rec       (out_rec),
      .inst_count    (inst_count),
      .cycle_count   (cycle_count),
      .halted        (halted),
      .done          (done),
      .overflow      (overflow),
      .drop_count    (drop_count)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clearInputs();
      ret_valid     = '0;
      ret_pc        = '0;
      ret_reg_write = '0;
      ret_wr_reg    = '0;
      ret_wr_data   = '0;
      ret_mem_read  = '0;
      ret_mem_write = '0;
      ret_mem_addr  = '0;
      ret_mem_data  = '0;
      ret_halt      = '0;
   endtask

   task automatic applyStimulus(input int c, input logic h, input logic rw, input logic mr,
                                input logic mw, input logic [15:0] pc, input logic [2:0] wr,
                                input logic [15:0] wd, input logic [15:0] ma, input logic [15:0] md);
      ret_valid[c]           = 1'b1;
      ret_halt[c]            = h;
      ret_reg_write[c]       = rw;
      ret_mem_read[c]        = mr;
      ret_mem_write[c]       = mw;
      ret_pc[16*c +: 16]     = pc;
      ret_wr_reg[3*c +: 3]   = wr;
      ret_wr_data[16*c +: 16]  = wd;
      ret_mem_addr[16*c +: 16] = ma;
      ret_mem_data[16*c +: 16] = md;
   endtask

   // Reference record for channel c as currently driven
   function automatic logic [BASE_W-1:0] modelRec(input logic [CNT_W-1:0] inum, input int c);
      logic [2:0]  k;
      logic [2:0]  wr;
      logic [15:0] wd;
      logic [15:0] ma;
      logic [15:0] md;
      if (ret_halt[c])                             k = 3'd5;
      else if (ret_reg_write[c] && ret_mem_write[c]) k = 3'd3;
      else if (ret_reg_write[c] && ret_mem_read[c])  k = 3'd2;
      else if (ret_reg_write[c])                   k = 3'd1;
      else if (ret_mem_write[c])                   k = 3'd4;
      else                                         k = 3'd0;
      wr = (k == 3'd1 || k == 3'd2 || k == 3'd3) ? ret_wr_reg[3*c +: 3]    : 3'd0;
      wd = (k == 3'd1 || k == 3'd2 || k == 3'd3) ? ret_wr_data[16*c +: 16] : 16'd0;
      ma = (k == 3'd2 || k == 3'd3 || k == 3'd4) ? ret_mem_addr[16*c +: 16] : 16'd0;
      md = (k == 3'd3 || k == 3'd4)              ? ret_mem_data[16*c +: 16] : 16'd0;
      return {inum, k, ret_pc[16*c +: 16], wr, wd, ma, md};
   endfunction

   // One clock: check the output port, update the scoreboard, advance, check counters
   task automatic clockStep();
      logic stop;
      if (out_ready) begin
         if (sb.size() > 0) begin
            checkOutput("deqValid", 128'(out_valid), 128'(1'b1));
            checkOutput("deqRec", 128'(out_rec[BASE_W-1:0]), 128'(sb.pop_front()));
         end else begin
            checkOutput("idleValid", 128'(out_valid), 128'(1'b0));
         end
      end else begin
         checkOutput("holdValid", 128'(out_valid), 128'(sb.size() > 0));
         if (sb.size() > 0)
            checkOutput("headRec", 128'(out_rec[BASE_W-1:0]), 128'(sb[0]));
      end
      if (!expHalted) begin
         stop = 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (!stop && ret_valid[c]) begin
               if (sb.size() < DEPTH) begin
                  sb.push_back(modelRec(expInst, c));
               end else begin
                  expDrop++;
                  expOverflow = 1'b1;
               end
               expInst++;
               if (ret_halt[c]) stop = 1'b1;
            end
         end
         expCycle++;
         if (stop) expHalted = 1'b1;
      end
      @(posedge clk);
      #1;
      clearInputs();
      checkOutput("instCount",  128'(inst_count),  128'(expInst));
      checkOutput("cycleCount", 128'(cycle_count), 128'(expCycle));
      checkOutput("halted",     128'(halted),      128'(expHalted));
      checkOutput("overflow",   128'(overflow),    128'(expOverflow));
      checkOutput("dropCount",  128'(drop_count),  128'(expDrop));
      checkOutput("done",       128'(done),        128'(expHalted && sb.size() == 0));
   endtask

   // Assert reset asynchronously, check everything clears at once, release after one edge
   task automatic resetDut();
      rst       = 1'b0;
      out_ready = 1'b0;
      clearInputs();
      #1;
      sb.delete();
      expInst     = '0;
      expCycle    = '0;
      expDrop     = '0;
      expHalted   = 1'b0;
      expOverflow = 1'b0;
      checkOutput("rstValid",    128'(out_valid),   128'(1'b0));
      checkOutput("rstRec",      128'(out_rec),     128'(0));
      checkOutput("rstInst",     128'(inst_count),  128'(0));
      checkOutput("rstCycle",    128'(cycle_count), 128'(0));
      checkOutput("rstHalted",   128'(halted),      128'(1'b0));
      checkOutput("rstDone",     128'(done),        128'(1'b0));
      checkOutput("rstOverflow", 128'(overflow),    128'(1'b0));
      checkOutput("rstDrop",     128'(drop_count),  128'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      rst         = 1'b1;
      out_ready   = 1'b0;
      clearInputs();
      #1;
      resetDut();

      // REG on ch0 and ST on ch1 together, junk in unused fields
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 3'd3, 16'h1234, 16'hAAAA, 16'h5555);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0012, 3'd6, 16'h9999, 16'h0040, 16'hBEEF);
      clockStep();
      out_ready = 1'b1;
      clockStep();
      clockStep();
      out_ready = 1'b0;

      // STU keeps every field, LD loses mem_data
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0020, 3'd5, 16'h0042, 16'h0042, 16'h0043);
      clockStep();
      applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0022, 3'd2, 16'h00AA, 16'h0100, 16'h7777);
      clockStep();
      out_ready = 1'b1;
      clockStep();
      clockStep();
      out_ready = 1'b0;

      // Two records per cycle with the consumer stalled: fill, then drop
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0200 + 4 * i), 3'd1, 16'(i),      16'd0, 16'd0);
         applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0202 + 4 * i), 3'd4, 16'(i + 16), 16'd0, 16'd0);
         clockStep();
      end
      // Full FIFO with a dequeue in the same cycle takes exactly one of two
      out_ready = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0300, 3'd0, 16'd0, 16'h0400, 16'h4444);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0302, 3'd0, 16'd0, 16'h0402, 16'h4545);
      clockStep();
      for (int i = 0; i < DEPTH + 1; i++) clockStep();
      out_ready = 1'b0;

      // HALT on ch0 hides the REG on ch1; later retirements are ignored
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100, 3'd7, 16'hDEAD, 16'hBEEF, 16'hCAFE);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0102, 3'd1, 16'h1111, 16'd0,   16'd0);
      clockStep();
      clockStep();
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0104, 3'd2, 16'h2222, 16'd0, 16'd0);
      out_ready = 1'b1;
      clockStep();
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0106, 3'd2, 16'h3333, 16'd0, 16'd0);
      applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0108, 3'd0, 16'd0, 16'h0500, 16'h5050);
      clockStep();
      clockStep();
      out_ready = 1'b0;

      // Reset in the middle of a stream with three records queued
      resetDut();
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0600, 3'd1, 16'h0A0A, 16'd0, 16'd0);
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0602, 3'd2, 16'h0B0B, 16'd0, 16'd0);
      clockStep();
      applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0604, 3'd0, 16'd0, 16'h0700, 16'h0C0C);
      clockStep();
      resetDut();
      applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0800, 3'd6, 16'h0D0D, 16'd0, 16'd0);
      clockStep();
      out_ready = 1'b1;
      clockStep();
      clockStep();
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Synthesizable retirement monitor for multi-issue and pipelined processor variants. Each cycle it samples up to NUM_CH retiring instructions and classifies each one as REG, LD, STU, ST, NOP or HALT. Each retirement is tagged with a sequence number (INUM) and buffered in a FIFO. Records drain through a valid/ready port to the trace writer or a debug bus. The block sits beside the processor core in `proc_hier`, fed by its writeback/memory-stage signals, and exposes instruction count, cycle count, halt and overflow status.

## Interface
- NUM_CH, 2, retire channels sampled per cycle (1..4); channel 0 is oldest
- DEPTH, 8, FIFO entries (power of two, ≥ NUM_CH)
- CNT_W, 32, width of the INUM, instruction and cycle counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ret_valid  in  NUM_CH  channel c retires an instruction this cycle
- ret_pc  in  16*NUM_CH  PC per channel
- ret_reg_write  in  NUM_CH  register file written
- ret_wr_reg  in  3*NUM_CH  destination register
- ret_wr_data  in  16*NUM_CH  register write data
- ret_mem_read  in  NUM_CH  memory read
- ret_mem_write  in  NUM_CH  memory write
- ret_mem_addr  in  16*NUM_CH  memory address
- ret_mem_data  in  16*NUM_CH  memory write data
- ret_halt  in  NUM_CH  halt instruction retiring
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts the record
- out_rec  out  REC_W  record {inum, kind[2:0], pc, wr_reg, wr_data, mem_addr, mem_data}
- inst_count  out  CNT_W  retirements accepted, including dropped ones
- cycle_count  out  CNT_W  cycles since reset release; freezes at halt
- halted  out  1  a HALT has retired (sticky)
- done  out  1  halted and FIFO empty
- overflow  out  1  sticky: at least one record dropped
- drop_count  out  CNT_W  records dropped

## Operation
- Kind, highest priority first:
  - halt → HALT (5)
  - reg_write & mem_write → STU (3)
  - reg_write & mem_read → LD (2)
  - reg_write → REG (1)
  - mem_write → ST (4)
  - otherwise NOP (0)
- Fields irrelevant to a record's kind are zeroed.
- Valid channels are processed in ascending index order.
  - Each is assigned inum = inst_count + (rank among valid channels).
  - inst_count advances by the number of valid channels accepted this cycle.
- Free space = DEPTH − occupancy + (out_valid & out_ready).
  - Records that fit are written in channel order.
  - The rest are dropped: overflow is set and drop_count is incremented per drop.
  - A dropped record still consumes its INUM.
- HALT on channel h: channels > h in the same cycle are ignored (not counted, not enqueued).
  - halted is set.
  - All ret_* inputs are ignored thereafter until reset.
- When a HALT record itself does not fit, it is still counted and halted is still set.
- cycle_count increments every cycle while not halted.
- FIFO pointers wrap modulo DEPTH; counters wrap modulo 2^CNT_W.

## Timing
- All outputs reset to 0 while rst is low, asynchronously; FIFO is empty after reset.
- A record sampled at edge N is visible on out_valid/out_rec after edge N, i.e. 1-cycle latency.
- out_rec holds stable while out_valid & !out_ready.
- One record is dequeued per edge where out_valid & out_ready.
- A full FIFO with a simultaneous dequeue accepts one new record that cycle.
- halted rises the cycle after the HALT edge.
  - cycle_count holds the value it had at that edge.
  - done rises the cycle after the last record is dequeued.
- rst asserted mid-operation discards the FIFO contents and clears all counters immediately.

## Configuration
- RTB_CYCLE_STAMP_EN
  - Defined: every record gains a CNT_W-bit cycle-stamp field (the cycle_count value at sampling) above inum, and REC_W grows by CNT_W.
  - Undefined: the field and its storage are absent.

## Structure
- Package rtb_pkg holds:
  - the kind encoding constants (KIND_NOP…KIND_HALT) and the record typedef;
  - REC_W derivation for both macro settings.
- Sub-module rtb_fifo: DEPTH-entry FIFO with up to NUM_CH writes and one read per cycle.
  - Exposes its free-slot count.
- Classification, INUM assignment, counters and halt logic live in the top module.

## Test plan
- NUM_CH=2. Ch0 REG r3=0x1234 @pc 0x0010; ch1 ST addr 0x0040 data 0xBEEF, same cycle.
  - Expected: two records, inum 0/1, kinds 1/4; inst_count=2.
- Ch0 stu (reg_write+mem_write, r5=0x0042, addr 0x0042) → kind 3, all fields intact.
  - Then ch0 ld → kind 2 with mem_data=0.
- out_ready=0, 2 records/cycle for 5 cycles, DEPTH=8.
  - Expected: 8 stored, 2 dropped; overflow=1; drop_count=2; inst_count=10.
  - Drained INUMs 0..7.
- Ch0 HALT and ch1 REG in the same cycle.
  - Expected: only the HALT is recorded; inst_count +1; halted=1 next cycle.
  - cycle_count frozen; done=1 after drain; later ret_valid ignored.
- Assert rst low mid-stream with 3 records queued.
  - Expected: out_valid=0 and all counters 0 immediately.
  - First post-reset record has inum 0.
